// File: rtl/color_sensor_frame.sv
// TCS3200 frame engine: gated edge counting per colour filter, clear-normalised RGB through a
// restoring divider, dark-detection hysteresis and dominant-colour decision.
module color_sensor_frame #(
  parameter int CNT_W         = 16,
  parameter int GATE_CYCLES   = 5000000,
  parameter int SETTLE_CYCLES = 1000,
  parameter int NORM_W        = 8,
  parameter int LUZ_LO        = 100,
  parameter int LUZ_HI        = 150
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sensor_out,
  input  logic                 start,
  input  logic                 continuous,
  output logic [1:0]           s2_s3,
  output logic                 busy,
  output logic [4*CNT_W-1:0]   raw_cnt,
  output logic [NORM_W-1:0]    red_norm,
  output logic [NORM_W-1:0]    green_norm,
  output logic [NORM_W-1:0]    blue_norm,
  output logic                 luz,
  output logic [1:0]           dominant,
  output logic                 sat,
  output logic                 frame_valid
);

  localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int STEP_W  = $clog2(NORM_W + 1);
  localparam logic [TMR_W-1:0]  GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST   = STEP_W'(NORM_W);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [CNT_W:0]    LUZ_LO_V    = (CNT_W+1)'(LUZ_LO);
  localparam logic [CNT_W:0]    LUZ_HI_V    = (CNT_W+1)'(LUZ_HI);

  typedef enum logic [2:0] {IDLE, SETTLE, GATE, DIVIDE, DONE} state_t;

  state_t              state, state_next;
  logic [TMR_W-1:0]    timer;
  logic [1:0]          ch;
  logic [CNT_W-1:0]    cnt [4];
  logic                sensor_p0, sensor_p1, sensor_p2, pulse;
  logic [1:0]          div_ch;
  logic [STEP_W-1:0]   step;
  logic [CNT_W-1:0]    rem, rem_next, div_num, div_den;
  logic [CNT_W:0]      shifted, diff;
  logic                div_ge, div_done, luz_new;
  logic [NORM_W-1:0]   quo, quo_next, div_res, norm_r, norm_g;

  function automatic logic [1:0] filter_code(input logic [1:0] c);
    case (c)
      2'd0:    return 2'b00;
      2'd1:    return 2'b11;
      2'd2:    return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic luz_next(input logic [CNT_W-1:0] clear, input logic prev);
    if ({1'b0, clear} < LUZ_LO_V)      return 1'b1;
    else if ({1'b0, clear} > LUZ_HI_V) return 1'b0;
    else                               return prev;
  endfunction

  function automatic logic [1:0] dom_pick(input logic [NORM_W-1:0] r, input logic [NORM_W-1:0] g,
                                          input logic [NORM_W-1:0] b, input logic dark);
    if (dark)                return 2'd0;
    else if (r > g && r > b) return 2'd1;
    else if (g > r && g > b) return 2'd2;
    else if (b > r && b > g) return 2'd3;
    else                     return 2'd0;
  endfunction

  // Stage boundary: pin -> two-flop synchroniser -> edge register
  assign pulse   = sensor_p1 & ~sensor_p2;
  assign busy    = (state != IDLE);
  assign luz_new = luz_next(cnt[3], luz);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start || continuous) state_next = SETTLE;
      SETTLE:  if (timer == SETTLE_LAST) state_next = GATE;
      GATE:    if (timer == GATE_LAST) state_next = (ch == 2'd3) ? DIVIDE : SETTLE;
      DIVIDE:  if (div_done && div_ch == 2'd2) state_next = DONE;
      DONE:    state_next = continuous ? SETTLE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Restoring divider: one load cycle, then one quotient bit per cycle; zero or
  // over-range divisions finish in the load cycle.
  always_comb begin
    div_num  = cnt[div_ch];
    div_den  = cnt[3];
    shifted  = {rem, 1'b0};
    div_ge   = (shifted >= {1'b0, div_den});
    diff     = shifted - {1'b0, div_den};
    rem_next = div_ge ? CNT_W'(diff) : CNT_W'(shifted);
    quo_next = NORM_W'({quo, div_ge});
    div_done = 1'b0;
    div_res  = '0;
    if (state == DIVIDE) begin
      if (step == '0) begin
        if (div_den == '0) begin
          div_done = 1'b1;
        end else if (div_num >= div_den) begin
          div_done = 1'b1;
          div_res  = '1;
        end
      end else if (step == STEP_LAST) begin
        div_done = 1'b1;
        div_res  = quo_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == DIVIDE) begin
      if (step == '0) begin
        rem <= div_num;
        quo <= '0;
      end else begin
        rem <= rem_next;
        quo <= quo_next;
      end
      if (div_done && div_ch == 2'd0) norm_r <= div_res;
      if (div_done && div_ch == 2'd1) norm_g <= div_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sensor_p0   <= 1'b0;
      sensor_p1   <= 1'b0;
      sensor_p2   <= 1'b0;
      timer       <= '0;
      ch          <= 2'd0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
      div_ch      <= 2'd0;
      step        <= '0;
      s2_s3       <= 2'b00;
      raw_cnt     <= '0;
      red_norm    <= '0;
      green_norm  <= '0;
      blue_norm   <= '0;
      luz         <= 1'b0;
      dominant    <= 2'd0;
      sat         <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      sensor_p0   <= sensor_out;
      sensor_p1   <= sensor_p0;
      sensor_p2   <= sensor_p1;
      frame_valid <= 1'b0;

      if (state_next != state || state == IDLE) timer <= '0;
      else                                      timer <= timer + 1'b1;

      if (state_next == SETTLE && state != SETTLE) begin
        if (state == GATE) begin
          ch    <= ch + 2'd1;
          s2_s3 <= filter_code(ch + 2'd1);
        end else begin
          ch    <= 2'd0;
          s2_s3 <= filter_code(2'd0);
          for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end
      end

      if (state == GATE && pulse) cnt[ch] <= sat_inc(cnt[ch]);

      if (state != DIVIDE) begin
        div_ch <= 2'd0;
        step   <= '0;
      end else if (div_done) begin
        div_ch <= div_ch + 2'd1;
        step   <= '0;
      end else begin
        step   <= step + 1'b1;
      end

      // Blue quotient lands this cycle, so it goes straight to the output register.
      if (state == DIVIDE && div_done && div_ch == 2'd2) begin
        raw_cnt     <= {cnt[3], cnt[2], cnt[1], cnt[0]};
        red_norm    <= norm_r;
        green_norm  <= norm_g;
        blue_norm   <= div_res;
        luz         <= luz_new;
        dominant    <= dom_pick(norm_r, norm_g, div_res, luz_new);
        sat         <= (cnt[0] == CNT_MAX) || (cnt[1] == CNT_MAX) ||
                       (cnt[2] == CNT_MAX) || (cnt[3] == CNT_MAX);
        frame_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_color_sensor_frame.sv
// Scoreboard bench for color_sensor_frame: directed frames with hand-computed results,
// plus a long-gate instance for counter saturation.
`timescale 1ns/100ps
module tb_color_sensor_frame;

  logic        clk, rst, sensor_out, start, continuous, start2, continuous2;
  logic [1:0]  s2_s3, s2_s3_2, dominant, dominant2;
  logic        busy, busy2, luz, luz2, sat, sat2, frame_valid, frame_valid2;
  logic [31:0] raw_cnt, raw_cnt2;
  logic [7:0]  red_norm, green_norm, blue_norm, red_norm2, green_norm2, blue_norm2;

  typedef struct {
    logic [31:0] raw;
    logic [7:0]  r, g, b;
    logic        luz;
    logic [1:0]  dom;
    logic        sat;
  } exp_t;

  exp_t q1[$], q2[$];
  logic [1:0] seq[$];
  int checks = 0, errors = 0, nframes = 0;
  int per_mode = 0, h_r = 0, h_g = 0, h_b = 0, h_c = 0;
  logic per_sig = 1'b0, set_sig = 1'b0;
  int since_sw = 1000;
  logic [1:0] code_seen = 2'b00, code_prev = 2'b00;
  logic fv_prev1 = 1'b0, fv_prev2 = 1'b0;

  color_sensor_frame #(.CNT_W(8), .GATE_CYCLES(100), .SETTLE_CYCLES(10), .NORM_W(8),
                       .LUZ_LO(16), .LUZ_HI(32)) dut (
    .clk(clk), .rst(rst), .sensor_out(sensor_out), .start(start), .continuous(continuous),
    .s2_s3(s2_s3), .busy(busy), .raw_cnt(raw_cnt), .red_norm(red_norm),
    .green_norm(green_norm), .blue_norm(blue_norm), .luz(luz), .dominant(dominant),
    .sat(sat), .frame_valid(frame_valid));

  color_sensor_frame #(.CNT_W(8), .GATE_CYCLES(1000), .SETTLE_CYCLES(10), .NORM_W(8),
                       .LUZ_LO(16), .LUZ_HI(32)) dut_long (
    .clk(clk), .rst(rst), .sensor_out(sensor_out), .start(start2), .continuous(continuous2),
    .s2_s3(s2_s3_2), .busy(busy2), .raw_cnt(raw_cnt2), .red_norm(red_norm2),
    .green_norm(green_norm2), .blue_norm(blue_norm2), .luz(luz2), .dominant(dominant2),
    .sat(sat2), .frame_valid(frame_valid2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Periodic sensor: half period h*12.5 ns per filter, phase tied to absolute time so a
  // filter change gives a clean waveform within a couple of clocks.
  initial begin
    longint tick;
    int h;
    tick = 0;
    #1;
    forever begin
      #12.5;
      tick++;
      case (s2_s3)
        2'b00:   h = h_r;
        2'b11:   h = h_g;
        2'b01:   h = h_b;
        default: h = h_c;
      endcase
      per_sig = (h == 0) ? 1'b0 : (((tick / h) % 2) == 1);
    end
  end

  // Edge burst confined to the first few cycles after a start or filter change.
  always @(negedge clk) begin
    if (start || s2_s3 != code_seen) since_sw = 0;
    else if (since_sw < 1000) since_sw++;
    code_seen = s2_s3;
    set_sig = (since_sw >= 1 && since_sw <= 5 && since_sw[0]);
  end

  always_comb begin
    case (per_mode)
      1:       sensor_out = per_sig;
      2:       sensor_out = set_sig;
      default: sensor_out = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] raw, input logic [7:0] r, input logic [7:0] g,
                              input logic [7:0] b, input logic l, input logic [1:0] d,
                              input logic s);
    exp_t e;
    e.raw = raw; e.r = r; e.g = g; e.b = b; e.luz = l; e.dom = d; e.sat = s;
    return e;
  endfunction

  task automatic cmp_frame(input string tag, input exp_t e, input logic [31:0] raw,
                           input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                           input logic l, input logic [1:0] d, input logic s);
    check({tag, "_raw_cnt"}, raw, e.raw);
    check({tag, "_red_norm"}, r, e.r);
    check({tag, "_green_norm"}, g, e.g);
    check({tag, "_blue_norm"}, b, e.b);
    check({tag, "_luz"}, l, e.luz);
    check({tag, "_dominant"}, d, e.dom);
    check({tag, "_sat"}, s, e.sat);
  endtask

  // Monitor: pops an expected frame whenever either instance presents frame_valid.
  always @(negedge clk) begin
    exp_t e;
    if (s2_s3 != code_prev) seq.push_back(s2_s3);
    code_prev = s2_s3;
    if (rst) begin
      fv_prev1 = 1'b0;
      fv_prev2 = 1'b0;
    end else begin
      if (fv_prev1) check("fv_single_cycle", frame_valid, 1'b0);
      if (fv_prev2) check("fv2_single_cycle", frame_valid2, 1'b0);
      fv_prev1 = frame_valid;
      fv_prev2 = frame_valid2;
      if (frame_valid) begin
        nframes++;
        check("frame_expected", q1.size() > 0, 1'b1);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          cmp_frame("frame", e, raw_cnt, red_norm, green_norm, blue_norm, luz, dominant, sat);
        end
      end
      if (frame_valid2) begin
        check("frame2_expected", q2.size() > 0, 1'b1);
        if (q2.size() > 0) begin
          e = q2.pop_front();
          cmp_frame("long", e, raw_cnt2, red_norm2, green_norm2, blue_norm2, luz2, dominant2,
                    sat2);
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_fv(input int which, input int budget, input string name);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if ((which == 1 && frame_valid) || (which == 2 && frame_valid2)) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, seen, 1'b1);
  endtask

  task automatic wait_code(input logic [1:0] code, input string name);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (s2_s3 == code) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, seen, 1'b1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_s2_s3"}, s2_s3, 2'b00);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_raw_cnt"}, raw_cnt, 32'd0);
    check({tag, "_norms"}, {red_norm, green_norm, blue_norm}, 24'd0);
    check({tag, "_luz"}, luz, 1'b0);
    check({tag, "_dominant"}, dominant, 2'd0);
    check({tag, "_sat"}, sat, 1'b0);
    check({tag, "_frame_valid"}, frame_valid, 1'b0);
  endtask

  task automatic set_dominant_pattern();
    per_mode = 1; h_r = 4; h_g = 2; h_b = 8; h_c = 1;
  endtask

  initial begin
    logic [31:0] packed_seq;
    rst = 1'b1; start = 1'b0; continuous = 1'b0; start2 = 1'b0; continuous2 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;

    set_dominant_pattern();
    repeat (50) @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_frames", nframes, 0);
    check("idle_raw_cnt", raw_cnt, 32'd0);

    // R=10 G=20 B=5 C=40 -> 64/128/32, green dominant
    seq.delete();
    q1.push_back(mk(32'h28_05_14_0A, 8'd64, 8'd128, 8'd32, 1'b0, 2'd2, 1'b0));
    pulse_start();
    wait_code(2'b11, "reach_green");
    repeat (20) @(negedge clk);
    pulse_start();
    wait_fv(1, 1000, "single_shot_done");
    check("busy_in_done", busy, 1'b1);
    @(negedge clk);
    check("busy_after_done", busy, 1'b0);
    packed_seq = 0;
    foreach (seq[i]) packed_seq = (packed_seq << 2) | 32'(seq[i]);
    check("s2_s3_seq_len", seq.size(), 3);
    check("s2_s3_seq", packed_seq, 32'h36);
    repeat (600) @(negedge clk);
    check("start_ignored_frames", nframes, 1);
    check("start_ignored_busy", busy, 1'b0);

    // Reset in the middle of the blue gate window
    pulse_start();
    wait_code(2'b01, "reach_blue");
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("mid_reset");
    rst = 1'b0;
    q1.push_back(mk(32'h28_05_14_0A, 8'd64, 8'd128, 8'd32, 1'b0, 2'd2, 1'b0));
    pulse_start();
    wait_fv(1, 1000, "post_reset_frame");
    @(negedge clk);
    check("post_reset_busy", busy, 1'b0);

    // Dark frames: no edges at all, then edges only inside settle windows
    per_mode = 0;
    q1.push_back(mk(32'd0, 8'd0, 8'd0, 8'd0, 1'b1, 2'd0, 1'b0));
    pulse_start();
    wait_fv(1, 1000, "no_edge_frame");
    per_mode = 2;
    q1.push_back(mk(32'd0, 8'd0, 8'd0, 8'd0, 1'b1, 2'd0, 1'b0));
    pulse_start();
    wait_fv(1, 1000, "settle_only_frame");
    repeat (3) @(negedge clk);

    // Continuous hysteresis: clear 10,20,40,20 -> luz 1,1,0,0
    per_mode = 1; h_r = 0; h_g = 0; h_b = 0; h_c = 4;
    q1.push_back(mk(32'h0A00_0000, 8'd0, 8'd0, 8'd0, 1'b1, 2'd0, 1'b0));
    q1.push_back(mk(32'h1400_0000, 8'd0, 8'd0, 8'd0, 1'b1, 2'd0, 1'b0));
    q1.push_back(mk(32'h2800_0000, 8'd0, 8'd0, 8'd0, 1'b0, 2'd0, 1'b0));
    q1.push_back(mk(32'h1400_0000, 8'd0, 8'd0, 8'd0, 1'b0, 2'd0, 1'b0));
    @(negedge clk) continuous = 1'b1;
    wait_fv(1, 1000, "cont_frame1");
    @(negedge clk);
    check("cont_no_gap1", busy, 1'b1);
    h_c = 2;
    wait_fv(1, 1000, "cont_frame2");
    @(negedge clk);
    check("cont_no_gap2", busy, 1'b1);
    h_c = 1;
    wait_fv(1, 1000, "cont_frame3");
    @(negedge clk);
    check("cont_no_gap3", busy, 1'b1);
    h_c = 2;
    continuous = 1'b0;
    wait_fv(1, 1000, "cont_frame4");
    @(negedge clk);
    check("cont_stop_busy", busy, 1'b0);

    // Long gate: every channel saturates
    per_mode = 1; h_r = 1; h_g = 1; h_b = 1; h_c = 1;
    q2.push_back(mk(32'hFFFF_FFFF, 8'd255, 8'd255, 8'd255, 1'b0, 2'd0, 1'b1));
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    wait_fv(2, 6000, "long_frame");
    repeat (5) @(negedge clk);

    check("q1_drained", q1.size(), 0);
    check("q2_drained", q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
